// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and default sizes for the two-master wishbone line-port arbiter
// that sits between the lc3b ifetch/data masters and unified memory.
package wishbone_arbiter_pkg;

  localparam int ARB_ADR_W   = 12;   // line address, byte address [15:4]
  localparam int ARB_DAT_W   = 128;  // one cache line
  localparam int ARB_SEL_W   = 16;   // one select bit per data byte
  localparam int ARB_TIMEOUT = 64;   // owned cycles without ACK before abort

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // Which master a granted state belongs to.
  function automatic arb_owner_t owner_of(input arb_state_t s);
    return (s == OWN_D) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// One wishbone link (classic cycle, line-wide data). The master modport is the
// initiator's view, the slave modport the responder's view.
interface wishbone_arbiter_if #(
  parameter int ADR_W = 12,
  parameter int DAT_W = 128,
  parameter int SEL_W = 16
) ();

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_m;  // master-to-slave write data
  logic [DAT_W-1:0] dat_s;  // slave-to-master read data
  logic             ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack
  );

endinterface

// File: rtl/wishbone_arbiter.sv
// Shares the single downstream memory port between the ifetch master (i_bus)
// and the data master (d_bus). One owner per transaction, grant held until
// ACK, round-robin on a tie, watchdog abort for transactions that never ACK.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int ADR_W   = ARB_ADR_W,
  parameter int DAT_W   = ARB_DAT_W,
  parameter int SEL_W   = ARB_SEL_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  wishbone_arbiter_if.slave  i_bus,
  wishbone_arbiter_if.slave  d_bus,
  wishbone_arbiter_if.master m_bus,
  output logic               timeout_err
);

  // At least 8 bits, wider only if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  arb_owner_t       last_owner;
  logic [CNT_W-1:0] count;

  logic             i_req;
  logic             d_req;
  logic             owned;
  logic             own_req;
  logic             own_we;
  logic [ADR_W-1:0] own_adr;
  logic [SEL_W-1:0] own_sel;
  logic [DAT_W-1:0] own_dat_m;
  logic             own_ack;
  logic             timeout_hit;

  // Select the current owner's request fields; nothing is driven while IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    i_req     = i_bus.cyc & i_bus.stb;
    d_req     = d_bus.cyc & d_bus.stb;
    owned     = 1'b0;
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_sel   = '0;
    own_dat_m = '0;
    unique case (state)
      OWN_I: begin
        owned     = 1'b1;
        own_req   = i_req;
        own_we    = i_bus.we;
        own_adr   = i_bus.adr;
        own_sel   = i_bus.sel;
        own_dat_m = i_bus.dat_m;
      end
      OWN_D: begin
        owned     = 1'b1;
        own_req   = d_req;
        own_we    = d_bus.we;
        own_adr   = d_bus.adr;
        own_sel   = d_bus.sel;
        own_dat_m = d_bus.dat_m;
      end
      default: ;
    endcase
    // An ACK only counts while the owner is still requesting; one that lands
    // in the same cycle as the owner's drop is swallowed.
    own_ack     = owned & own_req & m_bus.ack;
    timeout_hit = (TIMEOUT != 0) && owned && own_req && !m_bus.ack &&
                  (count == CNT_LAST);
  end

  assign m_bus.cyc   = own_req;
  assign m_bus.stb   = own_req;
  assign m_bus.we    = own_we;
  assign m_bus.adr   = own_adr;
  assign m_bus.sel   = own_sel;
  assign m_bus.dat_m = own_dat_m;

  assign i_bus.ack   = (state == OWN_I) & own_ack;
  assign d_bus.ack   = (state == OWN_D) & own_ack;
  assign i_bus.dat_s = (state == OWN_I) ? m_bus.dat_s : '0;
  assign d_bus.dat_s = (state == OWN_D) ? m_bus.dat_s : '0;
  assign timeout_err = timeout_hit;

  // Grant FSM, round-robin history and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every branch reads
    // the pre-edge values of state, last_owner and count.
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_D;
      count      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          count <= '0;
          if (i_req && (!d_req || last_owner == OWNER_D)) begin
            state <= OWN_I;
          end else if (d_req) begin
            state <= OWN_D;
          end
        end
        OWN_I, OWN_D: begin
          count <= count + 1'b1;
          if (!own_req) begin
            // Owner abandoned the cycle: free the port, keep the history.
            state <= IDLE;
          end else if (m_bus.ack || timeout_hit) begin
            state      <= IDLE;
            last_owner <= owner_of(state);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: a table of per-cycle vectors covering
// grant latency, round-robin, watchdog and abort, plus a hand-written
// asynchronous-reset sequence.
module tb_wishbone_arbiter;

  localparam logic [127:0] RD   = {16{8'hA5}};
  localparam logic [127:0] I_WD = {8{16'hC0DE}};
  localparam logic [127:0] D_WD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [15:0]  ISEL = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout_err;

  int checks = 0;
  int errors = 0;

  wishbone_arbiter_if #(.ADR_W(12), .DAT_W(128), .SEL_W(16)) ib ();
  wishbone_arbiter_if #(.ADR_W(12), .DAT_W(128), .SEL_W(16)) db ();
  wishbone_arbiter_if #(.ADR_W(12), .DAT_W(128), .SEL_W(16)) mb ();

  wishbone_arbiter #(
    .ADR_W(12), .DAT_W(128), .SEL_W(16), .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_bus       (ib),
    .d_bus       (db),
    .m_bus       (mb),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected in that same cycle.
  // own: 0 = nobody granted, 1 = ifetch, 2 = data master.
  typedef struct {
    string       name;
    logic        ic, is, dc, ds, dwe, ack;
    logic [11:0] ia, da;
    logic [15:0] dsel;
    int          own;
    logic        stb, iack, dack, terr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic ic, is, dc, ds, dwe, ack,
                     input logic [11:0] ia, da, input logic [15:0] dsel,
                     input int own, input logic stb, iack, dack, terr);
    vec_t v;
    v.name = nm; v.ic = ic; v.is = is; v.dc = dc; v.ds = ds; v.dwe = dwe;
    v.ack = ack; v.ia = ia; v.da = da; v.dsel = dsel; v.own = own;
    v.stb = stb; v.iack = iack; v.dack = dack; v.terr = terr;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    ib.cyc = v.ic; ib.stb = v.is; ib.adr = v.ia;
    db.cyc = v.dc; db.stb = v.ds; db.we = v.dwe; db.adr = v.da; db.sel = v.dsel;
    mb.ack = v.ack;
  endtask

  task automatic check_vec(input vec_t v);
    logic [11:0]  e_adr;
    logic [15:0]  e_sel;
    logic         e_we;
    logic [127:0] e_dat_m, e_i_dat, e_d_dat;
    e_adr = '0; e_sel = '0; e_we = 1'b0; e_dat_m = '0; e_i_dat = '0; e_d_dat = '0;
    if (v.own == 1) begin
      e_adr = v.ia; e_sel = ISEL; e_dat_m = I_WD; e_i_dat = RD;
    end else if (v.own == 2) begin
      e_adr = v.da; e_sel = v.dsel; e_we = v.dwe; e_dat_m = D_WD; e_d_dat = RD;
    end
    check({v.name, ".m_cyc"},       mb.cyc,      v.stb);
    check({v.name, ".m_stb"},       mb.stb,      v.stb);
    check({v.name, ".m_we"},        mb.we,       e_we);
    check({v.name, ".m_adr"},       mb.adr,      e_adr);
    check({v.name, ".m_sel"},       mb.sel,      e_sel);
    check({v.name, ".m_dat_m"},     mb.dat_m,    e_dat_m);
    check({v.name, ".i_ack"},       ib.ack,      v.iack);
    check({v.name, ".d_ack"},       db.ack,      v.dack);
    check({v.name, ".i_dat_s"},     ib.dat_s,    e_i_dat);
    check({v.name, ".d_dat_s"},     db.dat_s,    e_d_dat);
    check({v.name, ".timeout_err"}, timeout_err, v.terr);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fixed bus fields that no vector changes.
    ib.we = 1'b0; ib.sel = ISEL; ib.dat_m = I_WD;
    db.dat_m = D_WD; mb.dat_s = RD;

    // --- Reset state: requests and a stray ACK present, outputs must be 0.
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 12'h123;
    db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.adr = 12'h321; db.sel = 16'h00FF;
    mb.ack = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.m_cyc",       mb.cyc,      1'b0);
    check("reset.m_stb",       mb.stb,      1'b0);
    check("reset.m_we",        mb.we,       1'b0);
    check("reset.m_adr",       mb.adr,      12'h000);
    check("reset.m_sel",       mb.sel,      16'h0000);
    check("reset.m_dat_m",     mb.dat_m,    128'h0);
    check("reset.i_ack",       ib.ack,      1'b0);
    check("reset.d_ack",       db.ack,      1'b0);
    check("reset.i_dat_s",     ib.dat_s,    128'h0);
    check("reset.d_dat_s",     db.dat_s,    128'h0);
    check("reset.timeout_err", timeout_err, 1'b0);
    ib.cyc = 1'b0; ib.stb = 1'b0; db.cyc = 1'b0; db.stb = 1'b0; mb.ack = 1'b0;
    rst = 1'b0;

    // --- Tie from reset, both masters hold requests: I, D, I, D, one idle
    // cycle between grants; stray ACK in an idle cycle is ignored.
    //   name            ic is dc ds we ak  ia      da      dsel      own stb ia da te
    add("t2_req",        1, 1, 1, 1, 1, 0, 12'h100, 12'h200, 16'h0003, 0, 0, 0, 0, 0);
    add("t2_own_i",      1, 1, 1, 1, 1, 1, 12'h100, 12'h200, 16'h0003, 1, 1, 1, 0, 0);
    add("t3_idle_stray", 1, 1, 1, 1, 1, 1, 12'h100, 12'h200, 16'h0003, 0, 0, 0, 0, 0);
    add("t2_own_d",      1, 1, 1, 1, 1, 1, 12'h100, 12'h200, 16'h0003, 2, 1, 0, 1, 0);
    add("t3_idle2",      1, 1, 1, 1, 1, 0, 12'h100, 12'h200, 16'h0003, 0, 0, 0, 0, 0);
    add("t3_own_i_wait", 1, 1, 1, 1, 1, 0, 12'h100, 12'h200, 16'h0003, 1, 1, 0, 0, 0);
    add("t3_own_i_ack",  1, 1, 1, 1, 1, 1, 12'h100, 12'h200, 16'h0003, 1, 1, 1, 0, 0);
    add("t3_idle3",      1, 1, 1, 1, 1, 0, 12'h100, 12'h200, 16'h0003, 0, 0, 0, 0, 0);
    add("t3_own_d",      1, 1, 1, 1, 1, 1, 12'h100, 12'h200, 16'h0003, 2, 1, 0, 1, 0);
    add("t3_release",    0, 0, 0, 0, 0, 0, 12'h100, 12'h200, 16'h0003, 0, 0, 0, 0, 0);

    // --- Lone ifetch read of line 0x040, memory acks after 3 granted cycles.
    add("t1_req",        1, 1, 0, 0, 0, 0, 12'h040, 12'h000, 16'h0000, 0, 0, 0, 0, 0);
    add("t1_g1",         1, 1, 0, 0, 0, 0, 12'h040, 12'h000, 16'h0000, 1, 1, 0, 0, 0);
    add("t1_g2",         1, 1, 0, 0, 0, 0, 12'h040, 12'h000, 16'h0000, 1, 1, 0, 0, 0);
    add("t1_g3",         1, 1, 0, 0, 0, 0, 12'h040, 12'h000, 16'h0000, 1, 1, 0, 0, 0);
    add("t1_ack",        1, 1, 0, 0, 0, 1, 12'h040, 12'h000, 16'h0000, 1, 1, 1, 0, 0);
    add("t1_done",       0, 0, 0, 0, 0, 0, 12'h040, 12'h000, 16'h0000, 0, 0, 0, 0, 0);

    // --- Watchdog (TIMEOUT=8): D granted, never acked, I pending.
    add("t4_dreq",       0, 0, 1, 1, 0, 0, 12'h050, 12'h2A0, 16'hFFFF, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add($sformatf("t4_d_cyc%0d", k),
                         1, 1, 1, 1, 0, 0, 12'h050, 12'h2A0, 16'hFFFF, 2, 1, 0, 0, (k == 8));
    add("t4_after",      1, 1, 1, 1, 0, 0, 12'h050, 12'h2A0, 16'hFFFF, 0, 0, 0, 0, 0);
    add("t4_own_i",      1, 1, 1, 1, 0, 1, 12'h050, 12'h2A0, 16'hFFFF, 1, 1, 1, 0, 0);
    add("t4_release",    0, 0, 0, 0, 0, 0, 12'h050, 12'h2A0, 16'hFFFF, 0, 0, 0, 0, 0);

    // --- Abort: D serviced first so the history is D, then I drops stb while
    // the ACK arrives; stray ACK in IDLE; next tie must still go to I.
    add("t6_dreq",       0, 0, 1, 1, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);
    add("t6_own_d",      0, 0, 1, 1, 0, 1, 12'h0A0, 12'h0B0, 16'h00F0, 2, 1, 0, 1, 0);
    add("t6_idle",       0, 0, 0, 0, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);
    add("t6_ireq",       1, 1, 0, 0, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);
    add("t6_g1",         1, 1, 0, 0, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 1, 1, 0, 0, 0);
    add("t6_g2",         1, 1, 0, 0, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 1, 1, 0, 0, 0);
    add("t6_stb_drop",   1, 0, 0, 0, 0, 1, 12'h0A0, 12'h0B0, 16'h00F0, 1, 0, 0, 0, 0);
    add("t6_stray_ack",  1, 0, 0, 0, 0, 1, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);
    add("t6_tie",        1, 1, 1, 1, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);
    add("t6_tie_i",      1, 1, 1, 1, 0, 1, 12'h0A0, 12'h0B0, 16'h00F0, 1, 1, 1, 0, 0);
    add("t6_release",    0, 0, 0, 0, 0, 0, 12'h0A0, 12'h0B0, 16'h00F0, 0, 0, 0, 0, 0);

    // Reset was released one time unit after a rising edge; each vector is
    // driven there, checked 2 units later, and held until the next edge.
    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n]);
      #2;
      check_vec(vecs[n]);
      next_cycle();
    end
    // History is now I, so only a reset can make the next tie go to I.

    // --- Asynchronous reset in the middle of an OWN_D transaction.
    db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.adr = 12'h3C0; db.sel = 16'h0F0F;
    mb.ack = 1'b0;
    next_cycle();
    mb.ack = 1'b1;
    #2;
    check("t5_pre.m_stb", mb.stb, 1'b1);
    check("t5_pre.d_ack", db.ack, 1'b1);
    #1;
    rst = 1'b1;  // between edges: no clock edge until the checks below
    #1;
    check("t5_async.m_cyc",   mb.cyc,   1'b0);
    check("t5_async.m_stb",   mb.stb,   1'b0);
    check("t5_async.m_we",    mb.we,    1'b0);
    check("t5_async.d_ack",   db.ack,   1'b0);
    check("t5_async.d_dat_s", db.dat_s, 128'h0);
    next_cycle();
    rst = 1'b0;
    mb.ack = 1'b0;
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 12'h7E0;
    #2;
    check("t5_rel.m_stb", mb.stb, 1'b0);
    next_cycle();
    check("t5_grant.m_stb", mb.stb, 1'b1);
    check("t5_grant.m_adr", mb.adr, 12'h7E0);
    check("t5_grant.m_we",  mb.we,  1'b0);
    mb.ack = 1'b1;
    #2;
    check("t5_grant.i_ack", ib.ack, 1'b1);
    check("t5_grant.d_ack", db.ack, 1'b0);
    next_cycle();
    ib.cyc = 1'b0; ib.stb = 1'b0; db.cyc = 1'b0; db.stb = 1'b0; mb.ack = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the directed run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

endmodule
